// File: rtl/input_route_unit_pkg.sv
// Shared router definitions: directions, flit types, field positions and the
// west-first route-mask and output-selection helpers.
package input_route_unit_pkg;

  localparam int unsigned NUM_DIRS    = 5;
  localparam int unsigned TYPE_W      = 2;
  localparam int unsigned MAX_COORD_W = 8;

  localparam int unsigned IDX_L = 0;
  localparam int unsigned IDX_N = 1;
  localparam int unsigned IDX_E = 2;
  localparam int unsigned IDX_S = 3;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {
    DIR_L = 3'd0,
    DIR_N = 3'd1,
    DIR_E = 3'd2,
    DIR_S = 3'd3,
    DIR_W = 3'd4
  } dir_t;

  typedef enum logic [TYPE_W-1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_t;

  // West-first: any westward hop is taken first and alone; otherwise any
  // productive direction among E/N/S is allowed.
  function automatic logic [NUM_DIRS-1:0] route_mask(
    input logic [MAX_COORD_W-1:0] cur_x,
    input logic [MAX_COORD_W-1:0] cur_y,
    input logic [MAX_COORD_W-1:0] dest_x,
    input logic [MAX_COORD_W-1:0] dest_y
  );
    logic [NUM_DIRS-1:0] m;
    m = '0;
    if (dest_x < cur_x) begin
      m[IDX_W] = 1'b1;
    end else if ((dest_x == cur_x) && (dest_y == cur_y)) begin
      m[IDX_L] = 1'b1;
    end else begin
      if (dest_x > cur_x) m[IDX_E] = 1'b1;
      if (dest_y > cur_y) m[IDX_N] = 1'b1;
      if (dest_y < cur_y) m[IDX_S] = 1'b1;
    end
    return m;
  endfunction

  // Fixed priority E > N > S; W and L only ever appear alone in a mask.
  function automatic logic [NUM_DIRS-1:0] select_dir(input logic [NUM_DIRS-1:0] cand);
    logic [NUM_DIRS-1:0] s;
    s = '0;
    if (cand[IDX_E])      s[IDX_E] = 1'b1;
    else if (cand[IDX_N]) s[IDX_N] = 1'b1;
    else if (cand[IDX_S]) s[IDX_S] = 1'b1;
    else if (cand[IDX_W]) s[IDX_W] = 1'b1;
    else if (cand[IDX_L]) s[IDX_L] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/input_route_unit_if.sv
// FIFO-head, allocator and crossbar signals seen by one router input port.
interface input_route_unit_if #(
  parameter int unsigned FLIT_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned NF_W = $clog2(DEPTH) + 1;

  logic [FLIT_W-1:0] fifo_dout;
  logic [NF_W-1:0]   fifo_n_free;
  logic              fifo_pop;
  logic [4:0]        out_ready;
  logic [4:0]        req;
  logic              grant;
  logic [4:0]        out_sel;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_valid;
  logic              pkt_release;
  logic              err_drop;

  modport master (
    input  fifo_dout, fifo_n_free, out_ready, grant,
    output fifo_pop, req, out_sel, flit_out, flit_valid, pkt_release, err_drop
  );

  modport slave (
    output fifo_dout, fifo_n_free, out_ready, grant,
    input  fifo_pop, req, out_sel, flit_out, flit_valid, pkt_release, err_drop
  );
endinterface

// File: rtl/input_route_unit_route_compute.sv
// Combinational (cur, dest) -> 5-bit west-first route mask.
module input_route_unit_route_compute
  import input_route_unit_pkg::*;
#(
  parameter int unsigned COORD_W = 3
) (
  input  logic [COORD_W-1:0]  cur_x,
  input  logic [COORD_W-1:0]  cur_y,
  input  logic [COORD_W-1:0]  dest_x,
  input  logic [COORD_W-1:0]  dest_y,
  output logic [NUM_DIRS-1:0] mask
);

  assign mask = route_mask(MAX_COORD_W'(cur_x), MAX_COORD_W'(cur_y),
                           MAX_COORD_W'(dest_x), MAX_COORD_W'(dest_y));

endmodule

// File: rtl/input_route_unit.sv
// Router input-port front end: routes head flits, requests and locks an output
// port for the packet, and pops flits from the FIFO toward the crossbar.
module input_route_unit
  import input_route_unit_pkg::*;
#(
  parameter int unsigned FLIT_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned COORD_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  input_route_unit_if.master bus
);

  localparam int unsigned NF_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  state_t              state;
  logic [NUM_DIRS-1:0] lock;
  logic [NUM_DIRS-1:0] mask;
  logic [NUM_DIRS-1:0] mask_c;
  logic [NUM_DIRS-1:0] req_c;
  flit_type_t          head_type;
  logic                fifo_empty;
  logic                is_head;
  logic                is_last;
  logic                xfer_go;

  assign head_type  = flit_type_t'(bus.fifo_dout[FLIT_W-1 -: TYPE_W]);
  assign fifo_empty = (bus.fifo_n_free == NF_W'(DEPTH));
  assign is_head    = (head_type == FT_HEAD) || (head_type == FT_SINGLE);
  assign is_last    = (head_type == FT_TAIL) || (head_type == FT_SINGLE);
  assign req_c      = select_dir(mask & bus.out_ready);
  assign xfer_go    = (state == ST_XFER) && !fifo_empty && ((bus.out_ready & lock) != '0);

  input_route_unit_route_compute #(
    .COORD_W (COORD_W)
  ) u_route_compute (
    .cur_x  (cur_x),
    .cur_y  (cur_y),
    .dest_x (bus.fifo_dout[2*COORD_W-1 -: COORD_W]),
    .dest_y (bus.fifo_dout[COORD_W-1:0]),
    .mask   (mask_c)
  );

  // Packet-level state: mask captured on the head, lock held until the tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      lock  <= '0;
      mask  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty && is_head) begin
            mask  <= mask_c;
            state <= ST_ALLOC;
          end
        end
        ST_ALLOC: begin
          if (bus.grant && (req_c != '0)) begin
            lock  <= req_c;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (xfer_go && is_last) begin
            lock  <= '0;
            mask  <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          lock  <= '0;
          mask  <= '0;
        end
      endcase
    end
  end

  // Handshake strobes follow the current state and FIFO head in the same cycle.
  always_comb begin
    bus.req         = '0;
    bus.fifo_pop    = 1'b0;
    bus.flit_valid  = 1'b0;
    bus.pkt_release = 1'b0;
    bus.err_drop    = 1'b0;
    bus.out_sel     = lock;
    bus.flit_out    = bus.fifo_dout;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty && !is_head) begin
            bus.fifo_pop = 1'b1;
            bus.err_drop = 1'b1;
          end
        end
        ST_ALLOC: bus.req = req_c;
        ST_XFER: begin
          bus.fifo_pop    = xfer_go;
          bus.flit_valid  = xfer_go;
          bus.pkt_release = xfer_go && is_last;
        end
        default: bus.req = '0;
      endcase
    end
  end

endmodule

// File: doc/input_route_unit.md
Name: input_route_unit

Overview:
- Sits directly downstream of each router input-port FIFO.
- Inspects the FIFO head flit and computes a west-first, partially adaptive route for head flits.
- Requests an output port from the switch allocator, holds a wormhole lock until the tail flit, and pops flits out of the FIFO toward the crossbar.
- Sees only the FIFO's dout and n_free; empty is derived locally.

Parameters:
- FLIT_W, 32, flit width in bits. Must equal the FIFO DATA_WIDTH.
- DEPTH, 4, upstream FIFO depth. Used only to decode empty from n_free.
- COORD_W, 3, width of each mesh coordinate.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- cur_x  in  COORD_W  this router's X coordinate; quasi-static.
- cur_y  in  COORD_W  this router's Y coordinate; quasi-static.
- fifo_dout  in  FLIT_W  FIFO head flit.
- fifo_n_free  in  $clog2(DEPTH)+1  FIFO free-slot count; empty when equal to DEPTH.
- fifo_pop  out  1  pop strobe to the FIFO.
- out_ready  in  5  per-direction downstream space available; index L=0, N=1, E=2, S=3, W=4.
- req  out  5  one-hot output-port request to the switch allocator.
- grant  in  1  allocator grant for the current req; valid only while req != 0.
- out_sel  out  5  one-hot locked output direction; 0 when no port is locked.
- flit_out  out  FLIT_W  flit to the crossbar; equals fifo_dout.
- flit_valid  out  1  flit_out is transferred this cycle; equals fifo_pop on transfer.
- release  out  1  one-cycle pulse in the cycle the tail flit is transferred.
- err_drop  out  1  one-cycle pulse when a stray non-head flit is dropped.

Behaviour:
- Flit type field at [FLIT_W-1:FLIT_W-2]:
  - 00 BODY
  - 01 HEAD
  - 10 TAIL
  - 11 SINGLE (head and tail in one flit)
- Head flit fields: dest_x at [2*COORD_W-1:COORD_W], dest_y at [COORD_W-1:0]. Coordinates are unsigned. North means y increasing; east means x increasing.
- Route mask, registered when leaving IDLE:
  - dest_x < cur_x: W only.
  - dest == cur: L only.
  - Otherwise: E if dest_x > cur_x, N if dest_y > cur_y, S if dest_y < cur_y.
- Reset: state=IDLE; lock, mask and all outputs = 0.
- FSM states IDLE, ALLOC, XFER.
- IDLE, FIFO empty: stay.
- IDLE, head type HEAD or SINGLE: register mask, go to ALLOC. No pop.
- IDLE, head type BODY or TAIL:
  - fifo_pop=1 and err_drop=1 in the same cycle; flit_valid=0.
  - Stay in IDLE.
- ALLOC, output selection (combinational each cycle, from mask & out_ready):
  - Priority E > N > S among allowed, ready directions. W and L are sole candidates when present in the mask.
  - req = one-hot of the chosen direction, or 0 if none is ready. Re-evaluated every cycle; this is the adaptive step.
- ALLOC, grant=1 with req!=0: lock = req, go to XFER next cycle. grant while req==0 is ignored.
- XFER:
  - out_sel = lock.
  - fifo_pop = flit_valid = (FIFO non-empty) & (out_ready & lock != 0).
  - On a transfer whose type is TAIL or SINGLE: release=1, lock cleared, go to IDLE next cycle.
- XFER, HEAD seen mid-packet: forwarded as an ordinary flit. No special handling.
- XFER, FIFO empty or out_ready low: hold state, no pop. The lock persists indefinitely.
- Latency: head at FIFO output with grant in the same cycle → head transferred 2 cycles later (IDLE→ALLOC, ALLOC→XFER). Body flits stream at 1 flit/cycle under no backpressure.
- Reset mid-packet: return to IDLE and drop the lock. No release pulse. FIFO contents are handled by the FIFO's own reset.

Decomposition:
- router_pkg holds shared definitions:
  - dir_t enum (L, N, E, S, W) with index constants
  - flit_type_t enum
  - field-position constants
  - a route_mask function
- One sub-module, route_compute: combinational mapping (cur, dest) → 5-bit mask. The switch allocator and its tests reuse it.

Test Plan:
- Common setup: cur=(2,2), COORD_W=3, all out_ready=5'b11111 unless noted.
- HEAD dest (0,3), BODY, TAIL queued → mask=W, req=5'b10000; grant → 3 consecutive pops, out_sel=5'b10000, release on the 3rd pop, then IDLE.
- HEAD dest (4,4), out_ready=5'b00010 → req=5'b00010 (N). Raise E with grant still low → req switches to 5'b00100. Grant → lock E.
- SINGLE dest (2,2) → req=5'b00001, one pop with release=1, FIFO n_free back to DEPTH.
- Locked E mid-packet, out_ready[E]=0 for 2 cycles → fifo_pop=0 for those cycles, then resumes. Total pops equal the packet length.
- BODY flit at head in IDLE → fifo_pop=1, err_drop=1, flit_valid=0 for one cycle. Next HEAD is routed normally.
- Reset asserted in XFER after 1 of 3 flits → next cycle out_sel=0, req=0, state IDLE, no release pulse.
